// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch / decode / operand fetch / execute / write-back
// around an external ALU. Optional JZ branch support when SEQ_BRANCH_EN is defined.
module instr_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        halt,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  opcode,
  output logic [31:0] data,
  output logic [31:0] acc,
  output logic        execlk,
  input  logic [31:0] acc1,
  output logic [7:0]  pc,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_OPFETCH = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JZ   = 4'hE;

  logic [2:0]  r_state, w_next;
  logic [31:0] r_instr, r_data, r_acc;
  logic [7:0]  r_pc;
  logic [3:0]  r_opcode;
  logic        r_execlk, r_halt;
  logic [3:0]  w_op;
  logic        w_imm, w_jz, w_halt_seen;

  assign w_op        = r_instr[31:28];
  assign w_imm       = r_instr[27];
  // Current-cycle halt counts too, so a request in the last cycle still stops us.
  assign w_halt_seen = r_halt | halt;

`ifdef SEQ_BRANCH_EN
  assign w_jz = (w_op == OP_JZ);
`else
  assign w_jz = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (run && !halt) w_next = S_FETCH;
      S_FETCH:   if (mem_ack) w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_HALT) w_next = S_IDLE;
        else if (w_jz)       w_next = w_halt_seen ? S_IDLE : S_FETCH;
        else if (w_imm)      w_next = S_EXEC;
        else                 w_next = S_OPFETCH;
      end
      S_OPFETCH: if (mem_ack) w_next = S_EXEC;
      S_EXEC:    w_next = S_WB;
      S_WB:      w_next = w_halt_seen ? S_IDLE : S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_data   <= '0;
      r_acc    <= '0;
      r_pc     <= '0;
      r_opcode <= '0;
      r_execlk <= 1'b0;
      r_halt   <= 1'b0;
    end else begin
      r_state  <= w_next;
      // Registered from next-state so the strobe is exactly the EXEC cycle.
      r_execlk <= (w_next == S_EXEC);
      if (r_state == S_IDLE || w_next == S_IDLE) r_halt <= 1'b0;
      else if (halt)                             r_halt <= 1'b1;
      case (r_state)
        S_FETCH: if (mem_ack) begin
          r_instr <= mem_rdata;
          r_pc    <= r_pc + 8'd1;
        end
        S_DECODE: begin
          r_opcode <= w_op;
          if (w_jz) begin
            if (r_acc == 32'd0) r_pc <= r_instr[7:0];
          end else if (w_op != OP_HALT && w_imm) begin
            r_data <= {8'h00, r_instr[23:0]};
          end
        end
        S_OPFETCH: if (mem_ack) r_data <= mem_rdata;
        S_WB:      r_acc <= acc1;
        default: ;
      endcase
    end
  end

  assign mem_req  = (r_state == S_FETCH) || (r_state == S_OPFETCH);
  assign mem_addr = (r_state == S_OPFETCH) ? r_instr[7:0] : r_pc;
  assign opcode   = r_opcode;
  assign data     = r_data;
  assign acc      = r_acc;
  assign execlk   = r_execlk;
  assign pc       = r_pc;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: memory with programmable ack latency and a
// two-op ALU (opcode 1 subtracts, everything else adds).
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        mem_req, mem_ack, execlk, busy;
  logic [7:0]  mem_addr, pc;
  logic [31:0] mem_rdata, data, acc, acc1;
  logic [3:0]  opcode;

  logic [31:0] mem [256];
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  int          wait_cnt;
  int          exec_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          ex0;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .opcode(opcode), .data(data), .acc(acc), .execlk(execlk), .acc1(acc1),
    .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = ack_force | (mem_req & (wait_cnt >= ack_delay));
  assign acc1      = (opcode == 4'h1) ? acc - data : acc + data;

  always @(posedge clk or posedge rst)
    if (rst) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;

  always @(posedge clk) if (execlk) exec_cnt <= exec_cnt + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    chk(tag, {31'b0, busy}, 32'h0);
  endtask

  task automatic wait_fetch(input int budget, input logic [7:0] addr, input string tag);
    int n = 0;
    while (!(mem_req === 1'b1 && mem_addr === addr) && n < budget) begin @(negedge clk); n++; end
    chk(tag, {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, addr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]     = 32'h0800_0005;  // ADD imm 5
    mem[1]     = 32'h1000_0010;  // SUB mem[0x10]
    mem[2]     = 32'h0000_0011;  // ADD mem[0x11]
    mem[8'h10] = 32'd3;
    mem[8'h11] = 32'd10;

    // Reset state
    step(1);
    chk("rst_pc", {24'b0, pc}, 32'h0);
    chk("rst_acc", acc, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_memreq", {31'b0, mem_req}, 32'h0);
    rst = 1'b0;
    step(2);
    chk("idle_no_run", {31'b0, busy}, 32'h0);

    // ADD imm 5, ack on first request cycle: 4 cycles
    run = 1'b1;
    step(1);                                   // FETCH
    run = 1'b0;
    chk("t1_fetch", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h00});
    step(1);                                   // DECODE
    chk("t1_pc", {24'b0, pc}, 32'h1);
    chk("t1_decode_req", {31'b0, mem_req}, 32'h0);
    step(1);                                   // EXEC
    chk("t1_execlk", {31'b0, execlk}, 32'h1);
    chk("t1_data", data, 32'h5);
    step(1);                                   // WB
    chk("t1_wb_execlk", {31'b0, execlk}, 32'h0);
    step(1);                                   // FETCH addr 1
    chk("t1_acc", acc, 32'h5);
    chk("t1_pulses", exec_cnt, 32'd1);
    chk("t1_next_fetch", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h01});

    // SUB mem operand with 3-cycle ack delay
    step(1);                                   // DECODE
    ack_delay = 3;
    step(1);                                   // OPFETCH wait 0
    chk("t2_op_w0", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h10});
    step(1);
    chk("t2_op_w1", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h10});
    step(1);
    chk("t2_op_w2", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h10});
    chk("t2_no_execlk", {31'b0, execlk}, 32'h0);
    step(1);                                   // ack cycle
    chk("t2_op_w3", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h10});
    step(1);                                   // EXEC
    ack_delay = 0;
    chk("t2_data", data, 32'd3);
    chk("t2_opcode", {28'b0, opcode}, 32'h1);
    step(2);                                   // WB -> FETCH addr 2
    chk("t2_acc", acc, 32'd2);
    chk("t2_pulses", exec_cnt, 32'd2);
    chk("t2_next_fetch", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h02});

    // halt pulsed during OPFETCH: instruction completes, then IDLE
    step(1);                                   // DECODE
    ack_delay = 1;
    step(1);                                   // OPFETCH, no ack yet
    chk("t4_opfetch", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h11});
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    step(1);                                   // EXEC
    chk("t4_data", data, 32'd10);
    step(2);                                   // WB -> IDLE
    chk("t4_busy", {31'b0, busy}, 32'h0);
    chk("t4_acc", acc, 32'd12);
    chk("t4_pc", {24'b0, pc}, 32'h3);
    chk("t4_pulses", exec_cnt, 32'd3);

    // Restart at pc=3 and run to the 255 -> 0 wrap, then HALT at address 0
    ack_delay = 0;
    for (int i = 3; i < 256; i++) mem[i] = 32'h0800_0001;  // ADD imm 1
    mem[0] = 32'hF000_0000;
    run = 1'b1;
    step(1);
    run = 1'b0;
    chk("t3_restart", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h03});
    wait_fetch(2000, 8'hFF, "t3_reach_ff");
    step(1);                                   // DECODE
    chk("t3_wrap", {24'b0, pc}, 32'h0);
    wait_idle(50, "t3_idle");
    chk("t3_pc", {24'b0, pc}, 32'h1);
    chk("t3_acc", acc, 32'd265);
    chk("t3_pulses", exec_cnt, 32'd256);
    chk("t3_opcode", {28'b0, opcode}, 32'hF);
    chk("t3_execlk", {31'b0, execlk}, 32'h0);

    // run and halt together in IDLE: halt wins
    run = 1'b1; halt = 1'b1;
    step(1);
    run = 1'b0; halt = 1'b0;
    step(1);
    chk("t5_run_halt", {31'b0, busy}, 32'h0);
    chk("t5_pc", {24'b0, pc}, 32'h1);

    // Reset during a pending fetch, then a late ack
    ack_delay = 10;
    run = 1'b1;
    step(1);
    run = 1'b0;
    chk("t6_pending", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h01});
    ex0 = exec_cnt;
    rst = 1'b1;
    #1;
    chk("t6_async_req", {31'b0, mem_req}, 32'h0);
    chk("t6_async_busy", {31'b0, busy}, 32'h0);
    chk("t6_async_pc", {24'b0, pc}, 32'h0);
    chk("t6_async_acc", acc, 32'h0);
    step(1);
    rst = 1'b0;
    ack_force = 1'b1;
    step(2);
    ack_force = 1'b0;
    step(1);
    chk("t6_busy", {31'b0, busy}, 32'h0);
    chk("t6_memreq", {31'b0, mem_req}, 32'h0);
    chk("t6_pc", {24'b0, pc}, 32'h0);
    chk("t6_data", data, 32'h0);
    chk("t6_opcode", {28'b0, opcode}, 32'h0);
    chk("t6_execlk", {31'b0, execlk}, 32'h0);
    chk("t6_pulses", exec_cnt, ex0);

    // Opcode 0xE: branch when enabled, ordinary ALU op otherwise
    ack_delay = 0;
    mem[0]     = 32'hE000_0040;
    mem[1]     = 32'hF000_0000;
    mem[8'h40] = 32'h0800_0007;
    mem[8'h41] = 32'hE000_0040;
    mem[8'h42] = 32'hF000_0000;
    ex0 = exec_cnt;
    run = 1'b1;
    step(1);                                   // FETCH 0
    run = 1'b0;
    step(2);                                   // DECODE -> next state
    chk("t7_addr", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h40});
    chk("t7_execlk", {31'b0, execlk}, 32'h0);
`ifdef SEQ_BRANCH_EN
    chk("t7_pc_taken", {24'b0, pc}, 32'h40);
    wait_idle(100, "t7_idle");
    chk("t7_pc_final", {24'b0, pc}, 32'h43);
    chk("t7_acc", acc, 32'd7);
`else
    chk("t7_pc_seq", {24'b0, pc}, 32'h1);
    wait_idle(100, "t7_idle");
    chk("t7_pc_final", {24'b0, pc}, 32'h2);
    chk("t7_acc", acc, 32'h0800_0007);
`endif
    chk("t7_pulses", exec_cnt, ex0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
